// File: rtl/alu_ctrl_exec.sv
// alu_ctrl_exec: ALU control decode merged with a registered execute stage.
// Decodes alu_op/funct into a 4-bit control code, executes on WIDTH-bit
// operands and presents the result behind a valid/ready handshake.
// Optional macro ALU_MUL_EN adds an iterative shift-add multiplier (EXEC state).
module alu_ctrl_exec #(
    parameter int WIDTH   = 32,
    parameter int FUNCT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         alu_op,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic [3:0]         ctrl_out,
    output logic               illegal,
    output logic               busy
);

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_MUL = 4'b1000;
    localparam logic [3:0] CTRL_ILL = 4'b1111;

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_HOLD = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD = 2'd2} state_t;
`endif

    state_t             state, state_next;
    logic               accept;
    logic [3:0]         dec_ctrl;
    logic               dec_illegal;
    logic               dec_mul;
    logic [WIDTH-1:0]   exec_result;
    logic [WIDTH-1:0]   result_q;
    logic [3:0]         ctrl_q;
    logic               illegal_q;
    logic               unused_funct;

    // Only the low four funct bits take part in decode.
    assign unused_funct = ^(funct >> 4);

`ifdef ALU_MUL_EN
    localparam int CNT_W = $clog2(WIDTH);
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CNT_W-1:0] cnt;
    logic             mul_last;

    assign acc_next = acc + (mul_b[0] ? mul_a : '0);
    assign mul_last = (cnt == CNT_W'(WIDTH - 1));
`endif

    // Decode the control code and compute single-cycle results for the presented op.
    always_comb begin
        dec_ctrl    = CTRL_ILL;
        dec_illegal = 1'b1;
        dec_mul     = 1'b0;
        if (alu_op == 2'b00) begin
            dec_ctrl    = CTRL_ADD;
            dec_illegal = 1'b0;
        end else if (alu_op[0]) begin
            dec_ctrl    = CTRL_SUB;
            dec_illegal = 1'b0;
        end else begin
            case (funct[3:0])
                4'b0000: begin dec_ctrl = CTRL_ADD; dec_illegal = 1'b0; end
                4'b0010: begin dec_ctrl = CTRL_SUB; dec_illegal = 1'b0; end
                4'b0100: begin dec_ctrl = CTRL_AND; dec_illegal = 1'b0; end
                4'b0101: begin dec_ctrl = CTRL_OR;  dec_illegal = 1'b0; end
                4'b1010: begin dec_ctrl = CTRL_SLT; dec_illegal = 1'b0; end
`ifdef ALU_MUL_EN
                4'b1000: begin dec_ctrl = CTRL_MUL; dec_illegal = 1'b0; dec_mul = 1'b1; end
`endif
                default: begin dec_ctrl = CTRL_ILL; dec_illegal = 1'b1; end
            endcase
        end

        exec_result = '0;
        case (dec_ctrl)
            CTRL_ADD: exec_result = a + b;
            CTRL_SUB: exec_result = a - b;
            CTRL_AND: exec_result = a & b;
            CTRL_OR:  exec_result = a | b;
            CTRL_SLT: exec_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default:  exec_result = '0;
        endcase
    end

    // Handshake outputs and next-state selection.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            S_IDLE: in_ready = !rst;
`ifdef ALU_MUL_EN
            S_EXEC: busy = 1'b1;
`endif
            S_HOLD: begin
                out_valid = 1'b1;
                in_ready  = out_ready && !rst;
            end
            default: ;
        endcase

        accept = in_valid && in_ready;

        case (state)
            S_IDLE: if (accept) state_next = dec_mul ? state_t'(2'd1) : S_HOLD;
`ifdef ALU_MUL_EN
            S_EXEC: if (mul_last) state_next = S_HOLD;
`endif
            S_HOLD: begin
                if (accept)         state_next = dec_mul ? state_t'(2'd1) : S_HOLD;
                else if (out_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State register; reset abandons any in-flight op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Result registers and multiplier iteration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q  <= '0;
            ctrl_q    <= 4'b0000;
            illegal_q <= 1'b0;
`ifdef ALU_MUL_EN
            mul_a     <= '0;
            mul_b     <= '0;
            acc       <= '0;
            cnt       <= '0;
`endif
        end else if (accept) begin
            ctrl_q    <= dec_ctrl;
            illegal_q <= dec_illegal;
            result_q  <= dec_mul ? '0 : exec_result;
`ifdef ALU_MUL_EN
            mul_a     <= a;
            mul_b     <= b;
            acc       <= '0;
            cnt       <= '0;
`endif
        end
`ifdef ALU_MUL_EN
        else if (state == S_EXEC) begin
            acc   <= acc_next;
            mul_a <= mul_a << 1;
            mul_b <= mul_b >> 1;
            cnt   <= cnt + 1'b1;
            if (mul_last) result_q <= acc_next;
        end
`endif
    end

    assign result   = result_q;
    assign ctrl_out = ctrl_q;
    assign illegal  = illegal_q;
    assign zero     = out_valid && (result_q == '0);

endmodule

// File: doc/alu_ctrl_exec.md
Name: alu_ctrl_exec

Overview:
Parametrised successor to the combinational ALU-control decode, merged with execution. Decodes alu_op/funct into a 4-bit ALU control code, registers it, and executes the operation on WIDTH-bit operands. Uses a valid/ready handshake on input and output, so the execute stage can stall, and supports an optional iterative multiply. Sits between the register-read stage and memory/writeback.

Parameters:
WIDTH, 32, operand/result width (≥4)
FUNCT_W, 6, funct field width (≥4); only low 4 bits decoded

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  operation presented
in_ready  out  1  block can accept operation this cycle
alu_op  in  2  00 load/store, x1 branch, 10 R-type
funct  in  FUNCT_W  R-type function field
a  in  WIDTH  operand A
b  in  WIDTH  operand B
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  operation result
zero  out  1  result == 0
ctrl_out  out  4  decoded ALU control code of the held result
illegal  out  1  held result came from an undecodable funct
busy  out  1  multiply iteration in progress

Behaviour:
- Reset (async, any time incl. mid-multiply): state IDLE; out_valid=0, result=0, zero=0, ctrl_out=0000, illegal=0, busy=0; in-flight op discarded; in_ready=0 while rst high.
- Decode (on accept), priority order: alu_op=00 -> 0010 ADD; alu_op[0]=1 -> 0110 SUB; alu_op=10 -> funct[3:0]: 0000 ADD(0010), 0010 SUB(0110), 0100 AND(0000), 0101 OR(0001), 1010 SLT(0111), 1000 MUL(1000, optional); any other -> ctrl 1111, illegal=1, result 0.
- Arithmetic: ADD/SUB modulo 2^WIDTH, no carry out; SLT signed compare, result 1 or 0 zero-extended; MUL low WIDTH bits of unsigned product.
- zero computed from the final registered result, valid with out_valid.
- States: IDLE, EXEC, HOLD.
- IDLE: in_ready=1. Accept (in_valid&in_ready): single-cycle op -> result registered, HOLD next cycle (latency 1); MUL -> EXEC, busy=1, capture a, b, counter=0, accumulator=0.
- EXEC: one shift-add step per cycle (if b[0] acc+=a; a<<=1; b>>=1); after exactly WIDTH steps -> HOLD. MUL latency WIDTH+1 cycles from accept to out_valid. in_ready=0, busy=1.
- HOLD: out_valid=1, result/zero/ctrl_out/illegal stable until out_valid&out_ready.
  - Retire with no new op -> IDLE.
  - in_ready=out_ready in HOLD: simultaneous retire+accept loads the new op in the same cycle (back-to-back single-cycle throughput 1/cycle).
- Inputs ignored when in_ready=0; in_valid may drop without penalty.
- Unused funct high bits ignored.

Optional Feature:
ALU_MUL_EN: defined -> funct[3:0]=1000 executes iterative MUL via EXEC, busy functional. Undefined -> EXEC state and multiplier datapath absent, 1000 decodes illegal (ctrl 1111, result 0, latency 1), busy tied 0.

Test Plan:
- Reset then alu_op=00, a=5, b=7, out_ready=1 -> next cycle out_valid=1, result=12, ctrl_out=0010, zero=0.
- alu_op=01, a=b=0x1234 -> result=0, zero=1, ctrl_out=0110.
- alu_op=10 funct=101010, a=0xFFFFFFFF, b=1 -> result=1 (signed -1<1); funct=100100 a=0xF0F0 b=0xFF00 -> 0xF000; funct=000111 -> illegal=1, ctrl 1111, result 0.
- ALU_MUL_EN: funct=011000, a=6, b=7 -> busy 32 cycles, out_valid at cycle 33, result=42; out_ready=0 for 5 cycles -> result held, in_ready=0; without macro -> illegal=1 at cycle 1.
- Back-to-back: in_valid held 4 cycles with ADDs, out_ready=1 -> 4 results on consecutive cycles; out_ready dropped mid-stream -> in_ready=0, no loss or duplication.
- Assert rst during EXEC cycle 10 -> out_valid=0, busy=0 immediately; after release next ADD 2+2 -> 4 with latency 1.
